// File: rtl/sram_mem_ctrl_if.sv
// CPU-side request/acknowledge bus of the SRAM / video-RAM memory controller.
interface sram_mem_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic              busy;

  modport master (output req, we, addr, wdata, input rdata, ack, busy);
  modport slave  (input req, we, addr, wdata, output rdata, ack, busy);
endinterface

// File: rtl/sram_mem_ctrl.sv
// CPU word bus to byte-wide async SRAM (big-endian multi-beat), single-cycle VRAM port
// and an unmapped I/O hole that acks immediately.
module sram_mem_ctrl #(
  parameter int          DATA_W      = 16,
  parameter int          SRAM_W      = 8,
  parameter int          ADDR_W      = 16,
  parameter int          SRAM_ADDR_W = 21,
  parameter int          WAIT_CYCLES = 0,
  parameter int unsigned IO_BASE     = 'hC000,
  parameter int unsigned VRAM_BASE   = 'hF82F,
  parameter int          VRAM_ADDR_W = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  sram_mem_ctrl_if.slave         bus,
  output logic [SRAM_ADDR_W-1:0] sram_addr_o,
  inout  wire  [SRAM_W-1:0]      sram_data_io,
  output logic                   sram_ce_n_o,
  output logic                   sram_oe_n_o,
  output logic                   sram_we_n_o,
  output logic [VRAM_ADDR_W-1:0] vram_addr_o,
  output logic [DATA_W-1:0]      vram_wdata_o,
  output logic                   vram_we_o,
  input  logic [DATA_W-1:0]      vram_rdata_i
);
  localparam int BEATS  = DATA_W / SRAM_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WAIT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [ADDR_W-1:0] IO_B      = ADDR_W'(IO_BASE);
  localparam logic [ADDR_W-1:0] VRAM_B    = ADDR_W'(VRAM_BASE);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(WAIT_CYCLES);

  if ((DATA_W % SRAM_W) != 0) begin : g_bad_ratio
    $error("DATA_W must be an integer multiple of SRAM_W");
  end
  if (ADDR_W + BEAT_W > SRAM_ADDR_W) begin : g_bad_addr
    $error("ADDR_W + BEAT_W exceeds SRAM_ADDR_W");
  end

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, VRD, DONE} state_t;
  typedef enum logic [1:0] {RG_SRAM, RG_VRAM, RG_IO} region_t;

  state_t                 state_q, state_d;
  region_t                region_q, region_d, region_in;
  logic                   we_q, we_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [BEAT_W-1:0]      beat_q, beat_d;
  logic [WAIT_W-1:0]      wait_q, wait_d;
  logic [DATA_W-1:0]      rbuf_q, rbuf_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic [VRAM_ADDR_W-1:0] vram_addr_q, vram_addr_d;
  logic [DATA_W-1:0]      vram_wdata_q, vram_wdata_d;
  logic [ADDR_W-1:0]      voff;
  logic                   sram_act;

  // Beat 0 is the most-significant SRAM_W slice of the word.
  function automatic logic [SRAM_W-1:0] beat_slice(input logic [DATA_W-1:0] w,
                                                   input logic [BEAT_W-1:0] b);
    return SRAM_W'(w >> ((BEATS - 1 - int'(b)) * SRAM_W));
  endfunction

  always_comb begin
    voff      = bus.addr - VRAM_B;
    region_in = RG_IO;
    if (bus.addr < IO_B) begin
      region_in = RG_SRAM;
    end else if ((bus.addr >= VRAM_B) && (33'(voff) < (33'd1 << VRAM_ADDR_W))) begin
      region_in = RG_VRAM;
    end
  end

  always_comb begin
    state_d      = state_q;
    region_d     = region_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    beat_d       = beat_q;
    wait_d       = wait_q;
    rbuf_d       = rbuf_q;
    rdata_d      = rdata_q;
    vram_addr_d  = vram_addr_q;
    vram_wdata_d = vram_wdata_q;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          region_d = region_in;
          we_d     = bus.we;
          addr_d   = bus.addr;
          wdata_d  = bus.wdata;
          beat_d   = '0;
          wait_d   = '0;
          case (region_in)
            RG_SRAM: state_d = SETUP;
            RG_VRAM: begin
              state_d      = SETUP;
              vram_addr_d  = VRAM_ADDR_W'(voff);
              vram_wdata_d = bus.wdata;
            end
            default: begin
              state_d = DONE;
              if (!bus.we) rdata_d = '0;
            end
          endcase
        end
      end
      SETUP: begin
        if (region_q == RG_VRAM) begin
          state_d = we_q ? DONE : VRD;
        end else begin
          state_d = STROBE;
          wait_d  = '0;
        end
      end
      STROBE: begin
        if (wait_q == LAST_WAIT) begin
          wait_d = '0;
          if (!we_q) rbuf_d[(BEATS - 1 - int'(beat_q)) * SRAM_W +: SRAM_W] = sram_data_io;
          if (beat_q == LAST_BEAT) begin
            state_d = DONE;
            if (!we_q) rdata_d = rbuf_d;
          end else begin
            beat_d  = beat_q + BEAT_W'(1);
            state_d = SETUP;
          end
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      VRD: begin
        rdata_d = vram_rdata_i;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      region_q     <= RG_IO;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      beat_q       <= '0;
      wait_q       <= '0;
      rbuf_q       <= '0;
      rdata_q      <= '0;
      vram_addr_q  <= '0;
      vram_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      region_q     <= region_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      beat_q       <= beat_d;
      wait_q       <= wait_d;
      rbuf_q       <= rbuf_d;
      rdata_q      <= rdata_d;
      vram_addr_q  <= vram_addr_d;
      vram_wdata_q <= vram_wdata_d;
    end
  end

  // Strobes decode straight from state so an async reset releases the bus at once.
  assign sram_act     = (region_q == RG_SRAM) && ((state_q == SETUP) || (state_q == STROBE));
  assign sram_ce_n_o  = !sram_act;
  assign sram_oe_n_o  = !(sram_act && (state_q == STROBE) && !we_q);
  assign sram_we_n_o  = !(sram_act && (state_q == STROBE) && we_q);
  assign sram_addr_o  = sram_act ? SRAM_ADDR_W'({addr_q, beat_q}) : '0;
  assign sram_data_io = (sram_act && we_q) ? beat_slice(wdata_q, beat_q) : 'z;

  assign vram_addr_o  = vram_addr_q;
  assign vram_wdata_o = vram_wdata_q;
  assign vram_we_o    = (state_q == SETUP) && (region_q == RG_VRAM) && we_q;

  assign bus.rdata = rdata_q;
  assign bus.ack   = (state_q == DONE);
  assign bus.busy  = (state_q != IDLE);
endmodule

// File: doc/sram_mem_ctrl.md
SRAM_MEM_CTRL -- requirements
Module: sram_mem_ctrl

Interface
REQ-001 SHALL have parameters: DATA_W, default 16, CPU data width; SRAM_W, default 8, SRAM data width; DATA_W SHALL be an integer multiple of SRAM_W.
REQ-002 SHALL have parameters: ADDR_W, default 16, CPU word-address width; SRAM_ADDR_W, default 21, SRAM byte-address width; WAIT_CYCLES, default 0, extra strobe cycles per SRAM beat.
REQ-003 SHALL have parameters: IO_BASE, default 16'hC000, first I/O address; VRAM_BASE, default 16'hF82F, first video RAM address; VRAM_ADDR_W, default 12, video RAM address width.
REQ-004 SHALL define BEATS = DATA_W/SRAM_W and BEAT_W = clog2(BEATS), with a minimum of 1; ADDR_W+BEAT_W SHALL NOT exceed SRAM_ADDR_W.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  reset; asynchronous and active-high.
REQ-007 req  in  1  access request; sampled only when busy=0.
REQ-008 we  in  1  1=write, 0=read; qualified by req.
REQ-009 addr  in  ADDR_W  CPU word address.
REQ-010 wdata  in  DATA_W  write data.
REQ-011 rdata  out  DATA_W  read data; valid while ack=1 and held until the next completed read.
REQ-012 ack  out  1  one-cycle completion pulse for every accepted request.
REQ-013 busy  out  1  high from the cycle after acceptance through the ack cycle inclusive.
REQ-014 sram_addr  out  SRAM_ADDR_W  byte address = {zero pad, latched addr, beat index}.
REQ-015 sram_data  inout  SRAM_W  bidirectional SRAM data bus.
REQ-016 sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low SRAM strobes.
REQ-017 vram_addr  out  VRAM_ADDR_W  video RAM address; vram_wdata  out  DATA_W  write data; vram_we  out  1  write strobe.
REQ-018 vram_rdata  in  DATA_W  video RAM read data, valid one cycle after vram_addr is presented.

Function
REQ-019 SHALL accept a request on the rising edge where state=IDLE and req=1, latching addr, we and wdata; req while busy=1 SHALL be ignored without queuing.
REQ-020 SHALL decode the latched address as follows: SRAM if addr<IO_BASE; VRAM if addr>=VRAM_BASE and addr-VRAM_BASE<2**VRAM_ADDR_W; otherwise unmapped I/O.
REQ-021 SHALL use FSM states IDLE, SETUP, STROBE, VRD, DONE; DONE SHALL assert ack for one cycle and then return to IDLE.
REQ-022 SRAM path: each beat SHALL be one SETUP cycle plus WAIT_CYCLES+1 STROBE cycles; beats 0..BEATS-1 SHALL run in sequence; sram_ce_n=0 throughout.
REQ-023 Byte order SHALL be big-endian for both read and write: beat 0 carries the most-significant SRAM_W bits, and beat BEATS-1 carries the least-significant.
REQ-024 SRAM read: sram_oe_n SHALL be 0 in STROBE and 1 otherwise; the rdata slice SHALL be captured from sram_data at the final STROBE edge of each beat.
REQ-025 SRAM write: sram_data SHALL be driven with the beat's slice during SETUP and STROBE; sram_we_n SHALL be 0 in STROBE only; sram_oe_n SHALL remain 1.
REQ-026 sram_data SHALL be high-Z whenever a write beat is not in progress; the block SHALL never drive the bus while sram_oe_n=0.
REQ-027 SRAM latency: ack SHALL go high BEATS*(WAIT_CYCLES+2)+1 cycles after the accepting edge, which is 5 cycles with default parameters.
REQ-028 VRAM write: vram_addr = (addr-VRAM_BASE) truncated to VRAM_ADDR_W, vram_wdata=wdata and vram_we=1 for exactly one cycle, followed by ack on the next cycle.
REQ-029 VRAM read: vram_addr SHALL be presented for one cycle, vram_rdata SHALL be captured into rdata on the VRD edge, and ack SHALL follow in DONE; latency SHALL be 3 cycles from acceptance.
REQ-030 Unmapped I/O: a write SHALL be discarded and a read SHALL return rdata=0; ack SHALL go high 1 cycle after acceptance with no SRAM or VRAM activity.
REQ-031 In IDLE the outputs SHALL be: sram strobes=1, sram_addr=0, vram_we=0 and ack=0.
REQ-032 The beat counter SHALL reset to 0 on every acceptance, with no carry-over between requests.

Reset
REQ-033 On rst=1, the block SHALL immediately, without waiting for clk: enter IDLE; set rdata=0, ack=0, busy=0, sram_addr=0, sram_ce_n=sram_oe_n=sram_we_n=1, sram_data=Z, vram_addr=0, vram_wdata=0 and vram_we=0.
REQ-034 Reset mid-operation SHALL abort the access with no ack issued; the partial SRAM write is undefined.
REQ-035 The first request SHALL be accepted on the first rising edge after rst deasserts, provided req=1.

Verification
REQ-036 Write 16'hA55A to 0x0010, then read 0x0010 (defaults) -> SRAM bytes 0x20=0xA5 and 0x21=0x5A; read returns rdata=16'hA55A with ack 5 cycles after acceptance.
REQ-037 WAIT_CYCLES=2 read of 0x0001 -> sram_oe_n low for 3 cycles per beat, and ack 9 cycles after acceptance.
REQ-038 Write 16'h1234 to 0xF830 -> vram_addr=1, vram_wdata=16'h1234, one vram_we pulse, and no SRAM strobes asserted.
REQ-039 Read 0xC100 -> rdata=0 with ack 1 cycle after acceptance; a write to 0xC100 -> no strobes asserted.
REQ-040 req held high during an SRAM access -> exactly one ack per accepted request, and the second request is accepted only after returning to IDLE.
REQ-041 rst asserted during beat 1 of a write -> all strobes high and sram_data Z within the same cycle, with no ack issued.
